shift_chain: RTL and testbench
==============================

# shift_chain

Parametrised, bidirectional multi-bit shift register built from DEPTH stages of WIDTH bits each. It is driven by the complementary shift_en/shift_en_n enable pair used across the project, and it checks that pair for consistency. Supports parallel load, single-step shifting, and counted burst shifts with a busy/done handshake. It sits between the control FSM and the datapath registers as the project's generic scan/serialise block.

## Interface
- WIDTH, 8, bits per stage (≥1)
- DEPTH, 4, number of stages (≥2)
- CNT_W, $clog2(DEPTH+1), burst count width (derived; do not override)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- shift_en  in  1  shift enable, true polarity
- shift_en_n  in  1  shift enable, complement polarity
- dir  in  1  0 = shift toward stage DEPTH-1, 1 = toward stage 0
- load  in  1  parallel load strobe
- par_in  in  WIDTH*DEPTH  load data; stage i = bits [i*WIDTH +: WIDTH]
- ser_in  in  WIDTH  word entering the chain on a shift
- start  in  1  burst request (IDLE only)
- count  in  CNT_W  burst length in shifts
- par_out  out  WIDTH*DEPTH  all stages, same packing as par_in
- ser_out  out  WIDTH  exit word: stage DEPTH-1 if dir=0, stage 0 if dir=1 (combinational on dir)
- busy  out  1  burst in progress
- done  out  1  one-cycle burst completion pulse
- en_fault  out  1  registered flag for an invalid enable pair

## Operation
- Enable qualification:
  - en_ok = shift_en & ~shift_en_n.
  - shift_en == shift_en_n is invalid. No shift occurs, and en_fault = 1 on the following cycle. The flag is not sticky.
- Shift, dir=0: stage[0] ← ser_in; stage[i] ← stage[i-1].
- Shift, dir=1: stage[DEPTH-1] ← ser_in; stage[i] ← stage[i+1].
- dir is sampled on each shift edge.
- Per-edge priority: load > burst shift > manual shift > hold.
- FSM states:
  - IDLE
    - With en_ok and no start: one manual shift per edge.
    - start with count=0 → DONE, no shift.
    - start with count>0 → SHIFT, with remaining ← min(count, DEPTH).
  - SHIFT
    - busy=1.
    - Each edge with en_ok: shift, remaining−1.
    - Edges without en_ok stall; remaining is unchanged.
    - The edge performing the last shift → DONE.
    - start is ignored.
  - DONE
    - done=1 for exactly one cycle.
    - Manual shifting is allowed.
    - → IDLE.
- Load:
  - In any state, load copies par_in into all stages.
  - In SHIFT or DONE, load also forces IDLE: remaining ← 0, no done pulse.
  - load and start on the same IDLE edge: load wins, start is dropped.
- Reset: all stages 0, IDLE, remaining 0, busy 0, done 0, en_fault 0, applied immediately on rst_n low.

## Timing
- Load and shift results are visible on par_out/ser_out one cycle after the sampling edge.
- Burst accepted at edge t0:
  - busy rises after t0.
  - Shifts occur at edges t0+1 … t0+N when the enable is clean throughout.
  - Each stalled cycle adds one cycle.
- The last-shift edge drops busy and raises done for one cycle.
- Burst with count=0: done is high in the cycle after t0; busy never asserts.
- busy and done are never high together.
- rst_n deasserting mid-burst: the chain restarts in IDLE. The burst is lost and no done is issued.

## Structure
- Shared package shift_chain_pkg:
  - state enum {ST_IDLE, ST_SHIFT, ST_DONE}
  - DIR_FWD=1'b0, DIR_REV=1'b1 constants
- Sub-module shift_stage: one WIDTH-bit register with a load/shift-left/shift-right/hold mux and asynchronous clear. It is instantiated DEPTH times via generate.
- Top level holds the FSM, the remaining counter, enable qualification and en_fault.

## Test plan
- Reset, then load par_in=32'hDDCCBBAA (defaults) → par_out=32'hDDCCBBAA next cycle; ser_out=8'hDD (dir=0), 8'hAA (dir=1).
- From 32'hDDCCBBAA, start with count=2, dir=0, ser_in=8'h11, en_ok held:
  - busy high 2 cycles, then done 1 cycle.
  - par_out=32'hBBAA1111.
- Same burst with shift_en=shift_en_n=1 for one mid-burst cycle:
  - en_fault pulses.
  - One stall cycle; busy lasts 3 cycles.
  - Final data unchanged from the clean case.
- count=7 with DEPTH=4 → exactly 4 shifts, then done.
- Assert load during SHIFT → par_in captured, IDLE next cycle, no done pulse.
- Start with count=0 → done in the next cycle, busy stays 0, data unchanged.
- Pull rst_n low mid-burst asynchronously → outputs clear without a clock edge.

Source files
------------

// File: rtl/shift_chain_pkg.sv
// Shared types and constants for the shift_chain scan/serialise block.
package shift_chain_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_FWD, OP_REV} stage_op_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/shift_chain_if.sv
// Control/data bundle between the control FSM side (master) and shift_chain (slave).
interface shift_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     shift_en;
  logic                     shift_en_n;
  logic                     dir;
  logic                     load;
  logic [WIDTH*DEPTH-1:0]   par_in;
  logic [WIDTH-1:0]         ser_in;
  logic                     start;
  logic [CNT_W-1:0]         count;
  logic [WIDTH*DEPTH-1:0]   par_out;
  logic [WIDTH-1:0]         ser_out;
  logic                     busy;
  logic                     done;
  logic                     en_fault;

  modport master (
    output shift_en, shift_en_n, dir, load, par_in, ser_in, start, count,
    input  par_out, ser_out, busy, done, en_fault
  );

  modport slave (
    input  shift_en, shift_en_n, dir, load, par_in, ser_in, start, count,
    output par_out, ser_out, busy, done, en_fault
  );

endinterface

// File: rtl/shift_stage.sv
// One WIDTH-bit chain stage: load / forward / reverse / hold, cleared asynchronously.
module shift_stage
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stage_op_t        op,
  input  logic [WIDTH-1:0] load_word,
  input  logic [WIDTH-1:0] fwd_word,
  input  logic [WIDTH-1:0] rev_word,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      case (op)
        OP_LOAD: q <= load_word;
        OP_FWD:  q <= fwd_word;
        OP_REV:  q <= rev_word;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_chain.sv
// Bidirectional DEPTH x WIDTH shift chain with parallel load, counted bursts
// and consistency checking of the complementary shift enable pair.
module shift_chain
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  shift_chain_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic             fault_q;
  logic             en_ok, en_bad;
  logic             do_shift;
  stage_op_t        op;
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH*DEPTH-1:0] par_word;

  // Bursts longer than the chain saturate at DEPTH shifts.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] req);
    if (req > CNT_W'(DEPTH)) return CNT_W'(DEPTH);
    return req;
  endfunction

  assign en_ok  = bus.shift_en & ~bus.shift_en_n;
  assign en_bad = ~(bus.shift_en ^ bus.shift_en_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      fault_q   <= en_bad;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    do_shift      = 1'b0;
    if (bus.load) begin
      state_nxt     = ST_IDLE;
      remaining_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.count == '0) begin
              state_nxt = ST_DONE;
            end else begin
              state_nxt     = ST_SHIFT;
              remaining_nxt = sat_count(bus.count);
            end
          end else begin
            do_shift = en_ok;
          end
        end
        ST_SHIFT: begin
          if (en_ok) begin
            do_shift      = 1'b1;
            remaining_nxt = remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          do_shift  = en_ok;
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt     = ST_IDLE;
          remaining_nxt = '0;
        end
      endcase
    end

    op = OP_HOLD;
    if (bus.load)    op = OP_LOAD;
    else if (do_shift) op = (bus.dir == DIR_REV) ? OP_REV : OP_FWD;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] fwd_word;
    logic [WIDTH-1:0] rev_word;

    if (i == 0) begin : g_fwd_head
      assign fwd_word = bus.ser_in;
    end else begin : g_fwd_link
      assign fwd_word = stage_q[i-1];
    end

    if (i == DEPTH - 1) begin : g_rev_head
      assign rev_word = bus.ser_in;
    end else begin : g_rev_link
      assign rev_word = stage_q[i+1];
    end

    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .load_word (bus.par_in[i*WIDTH +: WIDTH]),
      .fwd_word  (fwd_word),
      .rev_word  (rev_word),
      .q         (stage_q[i])
    );
  end

  always_comb begin
    par_word = '0;
    for (int i = 0; i < DEPTH; i++) par_word[i*WIDTH +: WIDTH] = stage_q[i];
  end

  assign bus.par_out  = par_word;
  assign bus.ser_out  = (bus.dir == DIR_FWD) ? stage_q[DEPTH-1] : stage_q[0];
  assign bus.busy     = (state == ST_SHIFT);
  assign bus.done     = (state == ST_DONE);
  assign bus.en_fault = fault_q;

endmodule

// File: tb/tb_shift_chain.sv
// Bench for shift_chain: directed vector table, async-reset sequence, random run vs queue model.
module tb_shift_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PW    = WIDTH * DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  shift_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic             ld;
    logic [PW-1:0]    pin;
    logic             en;
    logic             en_n;
    logic             dr;
    logic [WIDTH-1:0] sin;
    logic             st;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    e_par;
    logic [WIDTH-1:0] e_ser;
    logic             e_busy;
    logic             e_done;
    logic             e_flt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic [PW-1:0] pin, input logic en, input logic en_n,
                     input logic dr, input logic [WIDTH-1:0] sin, input logic st,
                     input logic [CNT_W-1:0] cnt, input logic [PW-1:0] ep,
                     input logic [WIDTH-1:0] es, input logic eb, input logic ed, input logic ef);
    vec_t v;
    v.ld = ld; v.pin = pin; v.en = en; v.en_n = en_n; v.dr = dr; v.sin = sin;
    v.st = st; v.cnt = cnt; v.e_par = ep; v.e_ser = es;
    v.e_busy = eb; v.e_done = ed; v.e_flt = ef;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic ld, input logic [PW-1:0] pin, input logic en, input logic en_n,
                       input logic dr, input logic [WIDTH-1:0] sin, input logic st,
                       input logic [CNT_W-1:0] cnt);
    bus.load = ld; bus.par_in = pin; bus.shift_en = en; bus.shift_en_n = en_n;
    bus.dir = dr; bus.ser_in = sin; bus.start = st; bus.count = cnt;
  endtask

  task automatic idle_inputs();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  // Behavioural model: the chain is a queue of words, index 0 = stage 0.
  logic [WIDTH-1:0] m_q[$];
  int               m_left;
  bit               m_done;
  bit               m_flt;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < DEPTH; i++) m_q.push_back('0);
    m_left = 0; m_done = 0; m_flt = 0;
  endtask

  task automatic model_shift(input logic dr, input logic [WIDTH-1:0] sin);
    if (dr == 1'b0) begin
      m_q.push_front(sin);
      void'(m_q.pop_back());
    end else begin
      m_q.push_back(sin);
      void'(m_q.pop_front());
    end
  endtask

  task automatic model_step(input logic ld, input logic [PW-1:0] pin, input logic en,
                            input logic en_n, input logic dr, input logic [WIDTH-1:0] sin,
                            input logic st, input logic [CNT_W-1:0] cnt);
    bit ok;
    ok    = en && !en_n;
    m_flt = (en == en_n);
    if (ld) begin
      for (int i = 0; i < DEPTH; i++) m_q[i] = pin[i*WIDTH +: WIDTH];
      m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      m_done = 0;
      if (ok) begin
        model_shift(dr, sin);
        m_left--;
        if (m_left == 0) m_done = 1;
      end
    end else if (!m_done && st) begin
      if (cnt == 0) m_done = 1;
      else m_left = (int'(cnt) > DEPTH) ? DEPTH : int'(cnt);
    end else begin
      if (ok) model_shift(dr, sin);
      m_done = 0;
    end
  endtask

  task automatic compare_model(input int c, input logic dr);
    logic [PW-1:0]    ep;
    logic [WIDTH-1:0] es;
    for (int i = 0; i < DEPTH; i++) ep[i*WIDTH +: WIDTH] = m_q[i];
    es = (dr == 1'b0) ? m_q[DEPTH-1] : m_q[0];
    chk($sformatf("rnd%0d_par", c),   32'(bus.par_out),  32'(ep));
    chk($sformatf("rnd%0d_ser", c),   32'(bus.ser_out),  32'(es));
    chk($sformatf("rnd%0d_busy", c),  32'(bus.busy),     32'(m_left > 0));
    chk($sformatf("rnd%0d_done", c),  32'(bus.done),     32'(m_done));
    chk($sformatf("rnd%0d_fault", c), 32'(bus.en_fault), 32'(m_flt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic             r_ld, r_en, r_en_n, r_dr, r_st;
    logic [PW-1:0]    r_pin;
    logic [WIDTH-1:0] r_sin;
    logic [CNT_W-1:0] r_cnt;
    int               r;

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_par",   32'(bus.par_out),  32'h0);
    chk("rst_busy",  32'(bus.busy),     32'h0);
    chk("rst_done",  32'(bus.done),     32'h0);
    chk("rst_fault", 32'(bus.en_fault), 32'h0);
    rst_n = 1'b1;

    //  ld  pin           en  en_n dir ser    st  cnt   exp_par       ser    b  d  f
    add(1, 32'hDDCCBBAA, 0, 1, 0, 8'h00, 0, 3'd0, 32'hDDCCBBAA, 8'hDD, 0, 0, 0);
    add(0, 32'h0,        0, 1, 1, 8'h00, 0, 3'd0, 32'hDDCCBBAA, 8'hAA, 0, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h11, 1, 3'd2, 32'hDDCCBBAA, 8'hDD, 1, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h11, 0, 3'd0, 32'hCCBBAA11, 8'hCC, 1, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h11, 0, 3'd0, 32'hBBAA1111, 8'hBB, 0, 1, 0);
    add(0, 32'h0,        0, 1, 0, 8'h00, 0, 3'd0, 32'hBBAA1111, 8'hBB, 0, 0, 0);
    add(1, 32'hDDCCBBAA, 0, 1, 0, 8'h00, 0, 3'd0, 32'hDDCCBBAA, 8'hDD, 0, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h11, 1, 3'd2, 32'hDDCCBBAA, 8'hDD, 1, 0, 0);
    add(0, 32'h0,        1, 1, 0, 8'h11, 0, 3'd0, 32'hDDCCBBAA, 8'hDD, 1, 0, 1);
    add(0, 32'h0,        1, 0, 0, 8'h11, 0, 3'd0, 32'hCCBBAA11, 8'hCC, 1, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h11, 0, 3'd0, 32'hBBAA1111, 8'hBB, 0, 1, 0);
    add(0, 32'h0,        0, 1, 0, 8'h00, 0, 3'd0, 32'hBBAA1111, 8'hBB, 0, 0, 0);
    add(1, 32'hDDCCBBAA, 0, 1, 0, 8'h00, 0, 3'd0, 32'hDDCCBBAA, 8'hDD, 0, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h55, 1, 3'd7, 32'hDDCCBBAA, 8'hDD, 1, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h55, 0, 3'd0, 32'hCCBBAA55, 8'hCC, 1, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h55, 0, 3'd0, 32'hBBAA5555, 8'hBB, 1, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h55, 0, 3'd0, 32'hAA555555, 8'hAA, 1, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h55, 0, 3'd0, 32'h55555555, 8'h55, 0, 1, 0);
    add(0, 32'h0,        1, 0, 0, 8'h66, 0, 3'd0, 32'h55555566, 8'h55, 0, 0, 0);
    add(0, 32'h0,        1, 0, 1, 8'h77, 0, 3'd0, 32'h77555555, 8'h55, 0, 0, 0);
    add(1, 32'hDDCCBBAA, 0, 1, 0, 8'h00, 0, 3'd0, 32'hDDCCBBAA, 8'hDD, 0, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h11, 1, 3'd3, 32'hDDCCBBAA, 8'hDD, 1, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h11, 0, 3'd0, 32'hCCBBAA11, 8'hCC, 1, 0, 0);
    add(1, 32'h12345678, 1, 0, 0, 8'h11, 0, 3'd0, 32'h12345678, 8'h12, 0, 0, 0);
    add(0, 32'h0,        0, 1, 0, 8'h00, 0, 3'd0, 32'h12345678, 8'h12, 0, 0, 0);
    add(0, 32'h0,        1, 0, 0, 8'h99, 1, 3'd0, 32'h12345678, 8'h12, 0, 1, 0);
    add(0, 32'h0,        0, 1, 0, 8'h00, 0, 3'd0, 32'h12345678, 8'h12, 0, 0, 0);
    add(0, 32'h0,        0, 0, 0, 8'h99, 0, 3'd0, 32'h12345678, 8'h12, 0, 0, 1);
    add(0, 32'h0,        0, 1, 0, 8'h00, 0, 3'd0, 32'h12345678, 8'h12, 0, 0, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].ld, tbl[k].pin, tbl[k].en, tbl[k].en_n, tbl[k].dr, tbl[k].sin,
            tbl[k].st, tbl[k].cnt);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_par", k),   32'(bus.par_out),  32'(tbl[k].e_par));
      chk($sformatf("v%0d_ser", k),   32'(bus.ser_out),  32'(tbl[k].e_ser));
      chk($sformatf("v%0d_busy", k),  32'(bus.busy),     32'(tbl[k].e_busy));
      chk($sformatf("v%0d_done", k),  32'(bus.done),     32'(tbl[k].e_done));
      chk($sformatf("v%0d_fault", k), 32'(bus.en_fault), 32'(tbl[k].e_flt));
    end

    // Asynchronous reset in the middle of a burst.
    drive(1'b1, 32'hDDCCBBAA, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, '0);
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 3'd4);
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, '0);
    @(posedge clk); #1;
    chk("arst_pre_busy", 32'(bus.busy),    32'h1);
    chk("arst_pre_par",  32'(bus.par_out), 32'hCCBBAA33);
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_par",  32'(bus.par_out), 32'h0);
    chk("arst_busy", 32'(bus.busy),    32'h0);
    chk("arst_done", 32'(bus.done),    32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_post_busy", 32'(bus.busy),    32'h0);
    chk("arst_post_done", 32'(bus.done),    32'h0);
    chk("arst_post_par",  32'(bus.par_out), 32'h0);

    // Randomised run against the queue model.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 85)      begin r_en = 1'b1; r_en_n = 1'b0; end
      else if (r < 90) begin r_en = 1'b0; r_en_n = 1'b1; end
      else if (r < 95) begin r_en = 1'b1; r_en_n = 1'b1; end
      else             begin r_en = 1'b0; r_en_n = 1'b0; end
      r_ld  = ($urandom_range(0, 99) < 4);
      r_st  = ($urandom_range(0, 99) < 12);
      r_cnt = CNT_W'($urandom_range(0, 7));
      r_dr  = 1'($urandom_range(0, 1));
      r_sin = WIDTH'($urandom);
      r_pin = PW'($urandom);
      drive(r_ld, r_pin, r_en, r_en_n, r_dr, r_sin, r_st, r_cnt);
      @(posedge clk);
      model_step(r_ld, r_pin, r_en, r_en_n, r_dr, r_sin, r_st, r_cnt);
      #1;
      compare_model(c, r_dr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
